// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in/parallel-out receiver. Bits are gathered into a word starting at a
// start-of-frame strobe. Each finished word is handed on through a one-entry
// valid/ready buffer. A sticky flag records any word that was dropped because
// that buffer was still full.

module sipo_deserializer #(
    parameter int DATA_WIDTH = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sin,
    input  logic                  sin_valid,
    input  logic                  sin_sof,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_next;
    logic [DATA_WIDTH-1:0] sr_shifted;
    logic                  word_done;
    logic                  load_word;
    logic                  drop_word;

    // Shift register value if the current serial bit were taken in, in the configured bit order
    always_comb begin
        if (LSB_FIRST) begin
            sr_shifted = {sin, sr[DATA_WIDTH-1:1]};
        end else begin
            sr_shifted = {sr[DATA_WIDTH-2:0], sin};
        end
    end

    // State register: FSM state, bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sr    <= sr_next;
        end
    end

    // Next-state logic: a start-of-frame bit always restarts the word, even on what would be the last bit
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sr_next    = sr;
        if (sin_valid) begin
            if (sin_sof) begin
                sr_next    = sr_shifted;
                cnt_next   = CW'(1);
                state_next = SHIFT;
            end else if (state == SHIFT) begin
                sr_next = sr_shifted;
                if (word_done) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
        end
    end

    // Output decode: detect the word-completing bit and decide between loading it and dropping it
    always_comb begin
        word_done = sin_valid && !sin_sof && (state == SHIFT) && (cnt == CNT_LAST);
        load_word = word_done && (!out_valid || out_ready);
        drop_word = word_done && out_valid && !out_ready;
    end

    // One-entry output buffer: a new word may replace one being handed off in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load_word) begin
            out_data  <= sr_shifted;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow flag: a drop takes priority over a clear arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop_word) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer
// Drives two receivers in parallel, one LSB-first and one MSB-first, from the same
// serial inputs. Directed vector tables and hand sequences are followed by random
// traffic, which is compared against a frame-level reference model.

module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         sin;
    logic         sin_valid;
    logic         sin_sof;
    logic         out_ready;
    logic         clr_ovf;
    logic [W-1:0] data_lsb;
    logic [W-1:0] data_msb;
    logic         valid_lsb;
    logic         valid_msb;
    logic         ovf_lsb;
    logic         ovf_msb;

    int checks;
    int passes;

    // reference model state
    logic         m_valid;
    logic [W-1:0] m_data_lsb;
    logic [W-1:0] m_data_msb;
    logic         m_ovf;
    logic         m_active;
    int           m_cnt;
    logic         m_bits [W];

    typedef struct {
        logic         sv;
        logic         sbit;
        logic         sof;
        logic         ready;
        logic         clr;
        logic         ev;
        logic [W-1:0] ed_lsb;
        logic [W-1:0] ed_msb;
        logic         eo;
    } vec_t;

    vec_t tbl[$];

    sipo_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_sof   (sin_sof),
        .out_data  (data_lsb),
        .out_valid (valid_lsb),
        .out_ready (out_ready),
        .overflow  (ovf_lsb),
        .clr_ovf   (clr_ovf)
    );

    sipo_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_sof   (sin_sof),
        .out_data  (data_msb),
        .out_valid (valid_msb),
        .out_ready (out_ready),
        .overflow  (ovf_msb),
        .clr_ovf   (clr_ovf)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // single comparison with pass/fail bookkeeping
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // compare every output of both receivers against expected values
    task automatic checkOutput(input string name, input logic ev, input logic [W-1:0] el,
                               input logic [W-1:0] em, input logic eo);
        check({name, ".valid_lsb"}, {31'd0, valid_lsb}, {31'd0, ev});
        check({name, ".valid_msb"}, {31'd0, valid_msb}, {31'd0, ev});
        check({name, ".data_lsb"}, {28'd0, data_lsb}, {28'd0, el});
        check({name, ".data_msb"}, {28'd0, data_msb}, {28'd0, em});
        check({name, ".ovf_lsb"}, {31'd0, ovf_lsb}, {31'd0, eo});
        check({name, ".ovf_msb"}, {31'd0, ovf_msb}, {31'd0, eo});
    endtask

    task automatic modelReset();
        m_valid    = 1'b0;
        m_data_lsb = '0;
        m_data_msb = '0;
        m_ovf      = 1'b0;
        m_active   = 1'b0;
        m_cnt      = 0;
        for (int i = 0; i < W; i++) m_bits[i] = 1'b0;
    endtask

    // frame-level model: collect bits into a list, then weight them by position
    task automatic modelStep(input logic sv, input logic sbit, input logic sof,
                             input logic ready, input logic clr);
        logic         done;
        logic         drop;
        logic [W-1:0] wl;
        logic [W-1:0] wm;
        done = 1'b0;
        drop = 1'b0;
        wl   = '0;
        wm   = '0;
        if (sv) begin
            if (sof) begin
                m_bits[0] = sbit;
                m_cnt     = 1;
                m_active  = 1'b1;
            end else if (m_active) begin
                m_bits[m_cnt] = sbit;
                m_cnt++;
                if (m_cnt == W) begin
                    done     = 1'b1;
                    m_active = 1'b0;
                    m_cnt    = 0;
                    for (int i = 0; i < W; i++) begin
                        wl = wl | (W'(m_bits[i]) << i);
                        wm = wm | (W'(m_bits[i]) << (W - 1 - i));
                    end
                end
            end
        end
        if (done) begin
            if (!m_valid || ready) begin
                m_valid    = 1'b1;
                m_data_lsb = wl;
                m_data_msb = wm;
            end else begin
                drop = 1'b1;
            end
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // drive one cycle of inputs (called just after a falling edge) and advance to the next falling edge
    task automatic applyStimulus(input logic sv, input logic sbit, input logic sof,
                                 input logic ready, input logic clr);
        sin_valid = sv;
        sin       = sbit;
        sin_sof   = sof;
        out_ready = ready;
        clr_ovf   = clr;
        if (rst_n) modelStep(sv, sbit, sof, ready, clr);
        @(negedge clk);
    endtask

    // send one sof-aligned frame; bit i of w is the i-th bit on the wire
    task automatic sendFrame(input logic [W-1:0] w, input logic ready, input logic clr_last);
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b1, w[i], (i == 0), ready, (i == W - 1) && clr_last);
        end
    endtask

    function automatic void addVec(input logic sv, input logic sbit, input logic sof,
                                   input logic ready, input logic clr, input logic ev,
                                   input logic [W-1:0] el, input logic [W-1:0] em, input logic eo);
        vec_t v;
        v.sv = sv; v.sbit = sbit; v.sof = sof; v.ready = ready; v.clr = clr;
        v.ev = ev; v.ed_lsb = el; v.ed_msb = em; v.eo = eo;
        tbl.push_back(v);
    endfunction

    // main test sequence
    initial begin
        checks    = 0;
        passes    = 0;
        rst_n     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        modelReset();

        // bits 1,0,1,1 -> D / B, then handshake drops valid after one cycle
        addVec(1, 1, 1, 1, 0, 0, 4'h0, 4'h0, 0);
        addVec(1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 0);
        addVec(1, 1, 0, 1, 0, 0, 4'h0, 4'h0, 0);
        addVec(1, 1, 0, 1, 0, 1, 4'hD, 4'hB, 0);
        addVec(0, 0, 0, 1, 0, 0, 4'hD, 4'hB, 0);
        // frame A (MSB receiver sees 5), held with ready low while frame 6 shifts in
        addVec(1, 0, 1, 1, 0, 0, 4'hD, 4'hB, 0);
        addVec(1, 1, 0, 1, 0, 0, 4'hD, 4'hB, 0);
        addVec(1, 0, 0, 1, 0, 0, 4'hD, 4'hB, 0);
        addVec(1, 1, 0, 0, 0, 1, 4'hA, 4'h5, 0);
        addVec(1, 0, 1, 0, 0, 1, 4'hA, 4'h5, 0);
        addVec(1, 1, 0, 0, 0, 1, 4'hA, 4'h5, 0);
        addVec(1, 1, 0, 0, 0, 1, 4'hA, 4'h5, 0);
        // last bit of 6 lands on the handshake cycle: valid stays high, no overflow
        addVec(1, 0, 0, 1, 0, 1, 4'h6, 4'h6, 0);
        addVec(0, 0, 0, 1, 0, 0, 4'h6, 4'h6, 0);
        // partial 1,1 discarded by resync, then 0,0,1,0 -> 4 / 2
        addVec(1, 1, 1, 1, 0, 0, 4'h6, 4'h6, 0);
        addVec(1, 1, 0, 1, 0, 0, 4'h6, 4'h6, 0);
        addVec(1, 0, 1, 1, 0, 0, 4'h6, 4'h6, 0);
        addVec(1, 0, 0, 1, 0, 0, 4'h6, 4'h6, 0);
        addVec(1, 1, 0, 1, 0, 0, 4'h6, 4'h6, 0);
        addVec(1, 0, 0, 1, 0, 1, 4'h4, 4'h2, 0);
        addVec(0, 0, 0, 1, 0, 0, 4'h4, 4'h2, 0);
        // bits without sof while idle are ignored
        addVec(1, 1, 0, 1, 0, 0, 4'h4, 4'h2, 0);
        addVec(1, 1, 0, 1, 0, 0, 4'h4, 4'h2, 0);
        addVec(1, 0, 0, 1, 0, 0, 4'h4, 4'h2, 0);
        addVec(1, 1, 0, 1, 0, 0, 4'h4, 4'h2, 0);
        addVec(0, 0, 0, 1, 0, 0, 4'h4, 4'h2, 0);

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", 1'b0, 4'h0, 4'h0, 1'b0);
        rst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].sv, tbl[i].sbit, tbl[i].sof, tbl[i].ready, tbl[i].clr);
            checkOutput($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed_lsb, tbl[i].ed_msb, tbl[i].eo);
        end

        $display("[TB] overflow sequence");
        sendFrame(4'h3, 1'b0, 1'b0);
        checkOutput("ovf.first", 1'b1, 4'h3, 4'hC, 1'b0);
        sendFrame(4'h5, 1'b0, 1'b0);
        checkOutput("ovf.drop", 1'b1, 4'h3, 4'hC, 1'b1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("ovf.clear", 1'b1, 4'h3, 4'hC, 1'b0);
        sendFrame(4'h9, 1'b0, 1'b1);
        checkOutput("ovf.setwins", 1'b1, 4'h3, 4'hC, 1'b1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("ovf.sticky", 1'b0, 4'h3, 4'hC, 1'b1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("ovf.clear2", 1'b0, 4'h3, 4'hC, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 99) < 70), 1'($urandom), ($urandom_range(0, 99) < 8),
                          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 5));
            checkOutput($sformatf("rnd%0d", n), m_valid, m_data_lsb, m_data_msb, m_ovf);
        end

        // reset in the middle of a frame, with a pending word present
        sendFrame(4'h7, 1'b0, 1'b0);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset", 1'b0, 4'h0, 4'h0, 1'b0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("post_reset_nosof", 1'b0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("post_reset_frame", 1'b1, 4'hE, 4'h7, 1'b0);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 99) < 50), 1'($urandom), ($urandom_range(0, 99) < 15),
                          ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 10));
            checkOutput($sformatf("rndb%0d", n), m_valid, m_data_lsb, m_data_msb, m_ovf);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
